pulse_stats: RTL and testbench
==============================

# pulse_stats

Downstream companion to the pulse-width capture stage. Watches the same 4-bit sample vector `Q` that the capture stage sees, detects the cycle each all-ones run ends, and samples the capture stage's width output `f_count` one cycle later. Accumulates windows of 2^LOG2_N widths into min/max/sum/average and presents each window's results through a valid/ready handshake toward the readout logic.

## Interface
- `WIDTH`, 8: width of `f_count` and of the min/max/avg outputs.
- `LOG2_N`, 3: log2 of the window size. N = 2^LOG2_N samples per window.
- `DROP_W`, 8: width of the dropped-sample counter.

Ports:
- `clk`  in  1  — the single clock. All logic is on its rising edge.
- `rst`  in  1  — reset; synchronous, active-high.
- `en`  in  1  — when low, run ends are ignored (neither sampled nor counted as dropped).
- `Q`  in  4  — the sample vector that also feeds the capture stage.
- `f_count`  in  WIDTH  — registered run width from the capture stage.
- `stat_valid`  out  1  — window results are valid.
- `stat_ready`  in  1  — consumer accepts the results.
- `stat_min`  out  WIDTH  — minimum width in the window.
- `stat_max`  out  WIDTH  — maximum width in the window.
- `stat_sum`  out  WIDTH+LOG2_N  — exact sum of the window's widths.
- `stat_avg`  out  WIDTH  — `stat_sum >> LOG2_N`, truncated.
- `dropped`  out  DROP_W  — samples discarded while in HOLD; saturates at all-ones.

## Operation
- `hi_d <= (Q == 4'hF)`.
- `end_evt = hi_d & (Q != 4'hF) & en` (combinational).
- `pend <= end_evt`. In the cycle where `pend` = 1, `f_count` already holds the width of the run that just ended, because the capture stage updates it on the same edge. That value is the sample.
- States:
  - ST_COLLECT. On a sample:
    - `idx == 0`: load min = max = sum = x.
    - Otherwise: sum += x, min = min(min, x), max = max(max, x).
    - In both cases, `idx++`.
    - The sample taken when `idx == N-1` also latches the stat_* outputs (using the updated values) and moves to ST_HOLD.
  - ST_HOLD. `stat_valid` = 1 and all stat_* outputs are held stable.
    - A sample arriving in ST_HOLD increments `dropped` (saturating) and is otherwise discarded.
    - `stat_valid & stat_ready` at an edge moves to ST_COLLECT with `idx` = 0.
- State decisions use the current state. A sample on the same edge as the handshake is dropped.
- `dropped` clears only on reset.
- Arithmetic: the sum width `WIDTH+LOG2_N` cannot overflow. The average truncates. Widths the capture stage wrapped modulo 2^WIDTH are accumulated as-is.
- Reset values: `stat_valid` = 0; `stat_min`, `stat_max`, `stat_sum`, `stat_avg`, `dropped` = 0. Internally, state = ST_COLLECT and `idx`, `hi_d`, `pend`, sum = 0.
- Reset mid-window or in HOLD discards everything. The next window starts from `idx` = 0.
- A run already in progress when reset deasserts is sampled when it ends.

## Timing
- Cycle t: `end_evt`. Cycle t+1: `pend`, and the sample is taken at the end of t+1.
- If that sample is the N-th, `stat_valid` = 1 from cycle t+2.
- `end_evt` requires `Q` = F in the previous cycle, so events are at least 2 cycles apart. `pend` never overlaps itself.
- A pulse of width 1 (`Q` = F for one cycle) is a valid sample with value 1.
- `en` is checked only at `end_evt`. A pending sample completes even if `en` drops in cycle t+1.
- With `stat_ready` held high, `stat_valid` lasts exactly one cycle. A sample in that cycle is dropped.

## Structure
- Package `pulse_stats_pkg`: state enum (ST_COLLECT, ST_HOLD) and the constant `Q_ALL_HIGH = 4'hF`.
- One sub-module, `pulse_end_detect`: owns `hi_d`, `end_evt` gating with `en`, and `pend`. It outputs `sample_stb`.
- The top holds the FSM, accumulators, output registers and `dropped`.

## Test plan
All scenarios use WIDTH=8, LOG2_N=2, and a bench model of the capture stage driven by the same `Q`.
- Runs of 3, 5, 7, 9 cycles at `Q` = F, 2 idle cycles apart, `stat_ready` = 1 -> min 3, max 9, sum 24, avg 6; `stat_valid` is high for one cycle, 2 cycles after the 4th run ends.
- Runs 1, 1, 1, 2 -> sum 5, avg 1 (truncation), min 1, max 2. The width-1 runs are counted.
- Window complete with `stat_ready` = 0, then 2 more runs -> `dropped` = 2 and outputs unchanged. Then pulse `stat_ready` -> the next 4 runs of width 4 give avg 4.
- `Q` toggling only between 4'hE and 4'h7, plus one run ending while `en` = 0 -> no sample, `idx` unchanged, `dropped` = 0.
- `rst` pulsed while in HOLD with `stat_valid` = 1 -> the next cycle shows `stat_valid` = 0, all outputs 0, and a fresh window.
- DROP_W=2, 5 runs dropped in HOLD -> `dropped` saturates at 3.

Source files
------------

// File: rtl/pulse_stats_pkg.sv
// Shared types and constants for the pulse width statistics block.
package pulse_stats_pkg;

    typedef enum logic [0:0] {
        ST_COLLECT = 1'b0,
        ST_HOLD    = 1'b1
    } state_e;

    localparam logic [3:0] Q_ALL_HIGH = 4'hF;

endpackage

// File: rtl/pulse_end_detect.sv
// Flags the end of each all-ones run on q_i and strobes one cycle later,
// when the capture stage's width register holds that run's width.
module pulse_end_detect
    import pulse_stats_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en_i,
    input  logic [3:0] q_i,
    output logic       sample_stb_o
);

    logic hi_q;
    logic pend_q;
    logic end_evt;

    assign end_evt = hi_q & (q_i != Q_ALL_HIGH) & en_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q   <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            hi_q   <= (q_i == Q_ALL_HIGH);
            pend_q <= end_evt;
        end
    end

    assign sample_stb_o = pend_q;

endmodule

// File: rtl/pulse_stats.sv
// Windowed min/max/sum/average of captured pulse widths, presented through
// a valid/ready handshake. Samples arriving while results are held are counted.
//
// state      | meaning
// ST_COLLECT | accumulating samples, idx counts samples in the window
// ST_HOLD    | window results valid, waiting for stat_ready
module pulse_stats
    import pulse_stats_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int LOG2_N = 3,
    parameter int DROP_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [3:0]              Q,
    input  logic [WIDTH-1:0]        f_count,
    output logic                    stat_valid,
    input  logic                    stat_ready,
    output logic [WIDTH-1:0]        stat_min,
    output logic [WIDTH-1:0]        stat_max,
    output logic [WIDTH+LOG2_N-1:0] stat_sum,
    output logic [WIDTH-1:0]        stat_avg,
    output logic [DROP_W-1:0]       dropped
);

    localparam int SUM_W = WIDTH + LOG2_N;
    localparam logic [LOG2_N-1:0] IDX_LAST = '1;

    logic sample_stb;

    state_e             state_q, state_d;
    logic [LOG2_N-1:0]  idx_q, idx_d;
    logic [WIDTH-1:0]   min_q, min_d;
    logic [WIDTH-1:0]   max_q, max_d;
    logic [SUM_W-1:0]   sum_q, sum_d;
    logic [WIDTH-1:0]   out_min_q, out_min_d;
    logic [WIDTH-1:0]   out_max_q, out_max_d;
    logic [SUM_W-1:0]   out_sum_q, out_sum_d;
    logic [WIDTH-1:0]   out_avg_q, out_avg_d;
    logic [DROP_W-1:0]  dropped_q, dropped_d;
    logic [SUM_W-1:0]   x_ext;

    pulse_end_detect u_end_detect (
        .clk          (clk),
        .rst          (rst),
        .en_i         (en),
        .q_i          (Q),
        .sample_stb_o (sample_stb)
    );

    assign x_ext = {{LOG2_N{1'b0}}, f_count};

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        min_d     = min_q;
        max_d     = max_q;
        sum_d     = sum_q;
        out_min_d = out_min_q;
        out_max_d = out_max_q;
        out_sum_d = out_sum_q;
        out_avg_d = out_avg_q;
        dropped_d = dropped_q;
        case (state_q)
            ST_COLLECT: begin
                if (sample_stb) begin
                    if (idx_q == '0) begin
                        min_d = f_count;
                        max_d = f_count;
                        sum_d = x_ext;
                    end else begin
                        sum_d = sum_q + x_ext;
                        if (f_count < min_q) min_d = f_count;
                        if (f_count > max_q) max_d = f_count;
                    end
                    idx_d = idx_q + LOG2_N'(1);
                    // Last sample of the window publishes the updated totals.
                    if (idx_q == IDX_LAST) begin
                        out_min_d = min_d;
                        out_max_d = max_d;
                        out_sum_d = sum_d;
                        out_avg_d = sum_d[SUM_W-1:LOG2_N];
                        state_d   = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (sample_stb && (dropped_q != '1)) begin
                    dropped_d = dropped_q + DROP_W'(1);
                end
                if (stat_ready) begin
                    state_d = ST_COLLECT;
                    idx_d   = '0;
                end
            end
            default: state_d = ST_COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_COLLECT;
            idx_q     <= '0;
            min_q     <= '0;
            max_q     <= '0;
            sum_q     <= '0;
            out_min_q <= '0;
            out_max_q <= '0;
            out_sum_q <= '0;
            out_avg_q <= '0;
            dropped_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            min_q     <= min_d;
            max_q     <= max_d;
            sum_q     <= sum_d;
            out_min_q <= out_min_d;
            out_max_q <= out_max_d;
            out_sum_q <= out_sum_d;
            out_avg_q <= out_avg_d;
            dropped_q <= dropped_d;
        end
    end

    assign stat_valid = (state_q == ST_HOLD);
    assign stat_min   = out_min_q;
    assign stat_max   = out_max_q;
    assign stat_sum   = out_sum_q;
    assign stat_avg   = out_avg_q;
    assign dropped    = dropped_q;

endmodule

// File: tb/tb_pulse_stats.sv
// Bench for pulse_stats: a capture-stage model feeds f_count, and window
// results are compared against statistics computed from the driven run widths.
module tb_pulse_stats;

    localparam int WIDTH  = 8;
    localparam int LOG2_N = 2;
    localparam int N      = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b1;
    logic        stat_ready = 1'b0;
    logic [3:0]  Q = 4'h0;
    logic [7:0]  f_count = 8'h0;

    logic        stat_valid, v2;
    logic [7:0]  stat_min, stat_max, stat_avg, min2, max2, avg2;
    logic [9:0]  stat_sum, sum2;
    logic [7:0]  dropped;
    logic [1:0]  dropped2;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_drop = 0;
    int run_cnt  = 0;

    pulse_stats #(.WIDTH(WIDTH), .LOG2_N(LOG2_N), .DROP_W(8)) dut (
        .clk(clk), .rst(rst), .en(en), .Q(Q), .f_count(f_count),
        .stat_valid(stat_valid), .stat_ready(stat_ready),
        .stat_min(stat_min), .stat_max(stat_max), .stat_sum(stat_sum),
        .stat_avg(stat_avg), .dropped(dropped)
    );

    pulse_stats #(.WIDTH(WIDTH), .LOG2_N(LOG2_N), .DROP_W(2)) dut_sat (
        .clk(clk), .rst(rst), .en(en), .Q(Q), .f_count(f_count),
        .stat_valid(v2), .stat_ready(stat_ready),
        .stat_min(min2), .stat_max(max2), .stat_sum(sum2),
        .stat_avg(avg2), .dropped(dropped2)
    );

    always #5 clk = ~clk;

    // Capture stage: registers the length of each all-ones run as it ends.
    always @(posedge clk) begin
        if (Q == 4'hF) begin
            run_cnt <= run_cnt + 1;
        end else begin
            if (run_cnt != 0) f_count <= 8'(run_cnt);
            run_cnt <= 0;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [33:0] exp_stats(input int w[4]);
        int mn, mx, s;
        mn = w[0];
        mx = w[0];
        s  = 0;
        for (int i = 0; i < N; i++) begin
            s += w[i];
            if (w[i] < mn) mn = w[i];
            if (w[i] > mx) mx = w[i];
        end
        return {8'(mn), 8'(mx), 10'(s), 8'(s / N)};
    endfunction

    function automatic int sat(input int v, input int lim);
        return (v > lim) ? lim : v;
    endfunction

    function automatic logic [3:0] idle_q();
        logic [3:0] v;
        v = 4'($urandom_range(0, 14));
        return v;
    endfunction

    task automatic realign();
        @(posedge clk);
        #1;
    endtask

    task automatic send_run(input int w, input int gap, input logic en_end);
        Q = 4'hF;
        repeat (w) @(posedge clk);
        #1;
        Q  = idle_q();
        en = en_end;
        for (int i = 0; i < gap; i++) begin
            @(posedge clk);
            #1;
            en = 1'b1;
        end
    endtask

    task automatic send_window(input int w[4]);
        for (int i = 0; i < N - 1; i++) send_run(w[i], 2, 1'b1);
        send_run(w[N-1], 0, 1'b1);
    endtask

    task automatic wait_valid(output int k);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (stat_valid !== 1'b1 && k < 40);
    endtask

    task automatic random_widths(output int w[4]);
        for (int i = 0; i < N; i++) w[i] = int'($urandom_range(1, 40));
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; Q = 4'h0; stat_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (stat_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valid: got %b want 0", stat_valid);
        end
        n_checks++;
        if ({stat_min, stat_max, stat_sum, stat_avg} !== 34'h0) begin
            n_fail++;
            $display("FAIL reset_stats: got %h want 0", {stat_min, stat_max, stat_sum, stat_avg});
        end
        n_checks++;
        if (dropped !== 8'h0 || dropped2 !== 2'h0) begin
            n_fail++;
            $display("FAIL reset_dropped: got %0d/%0d want 0/0", dropped, dropped2);
        end
        realign();
    endtask

    task automatic test_basic();
        int w[4];
        int k;
        w = '{3, 5, 7, 9};
        stat_ready = 1'b1;
        send_window(w);
        wait_valid(k);
        n_checks++;
        if (k !== 3 || stat_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_latency: valid after %0d cycles (valid=%b) want 3", k, stat_valid);
        end
        n_checks++;
        if ({stat_min, stat_max, stat_sum, stat_avg} !== exp_stats(w)) begin
            n_fail++;
            $display("FAIL basic_stats: got %h want %h", {stat_min, stat_max, stat_sum, stat_avg}, exp_stats(w));
        end
        realign();
        @(negedge clk);
        n_checks++;
        if (stat_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_one_cycle: valid=%b want 0 after handshake", stat_valid);
        end
        realign();
    endtask

    task automatic test_truncation();
        int w[4];
        int k;
        w = '{1, 1, 1, 2};
        stat_ready = 1'b1;
        send_window(w);
        wait_valid(k);
        n_checks++;
        if (k !== 3 || {stat_min, stat_max, stat_sum, stat_avg} !== exp_stats(w)) begin
            n_fail++;
            $display("FAIL trunc_stats: got %h after %0d cycles want %h after 3",
                     {stat_min, stat_max, stat_sum, stat_avg}, k, exp_stats(w));
        end
        realign();
    endtask

    task automatic test_random_windows();
        int w[4];
        int k;
        stat_ready = 1'b1;
        for (int n = 0; n < 6; n++) begin
            random_widths(w);
            for (int i = 0; i < N - 1; i++) send_run(w[i], int'($urandom_range(1, 4)), 1'b1);
            send_run(w[N-1], 0, 1'b1);
            wait_valid(k);
            n_checks++;
            if (k !== 3 || {stat_min, stat_max, stat_sum, stat_avg} !== exp_stats(w)) begin
                n_fail++;
                $display("FAIL random_window%0d: got %h after %0d cycles want %h after 3",
                         n, {stat_min, stat_max, stat_sum, stat_avg}, k, exp_stats(w));
            end
            realign();
        end
    endtask

    task automatic test_ignored_events();
        int a, b, c, d, e;
        int w[4];
        int k;
        stat_ready = 1'b1;
        a = int'($urandom_range(1, 20)); b = int'($urandom_range(1, 20));
        c = int'($urandom_range(1, 20)); d = int'($urandom_range(1, 20));
        e = int'($urandom_range(1, 20));
        send_run(a, 2, 1'b1);
        send_run(b, 2, 1'b1);
        for (int i = 0; i < 20; i++) begin
            Q = ($urandom_range(0, 1) == 0) ? 4'hE : 4'h7;
            realign();
        end
        send_run(c, 3, 1'b0);
        @(negedge clk);
        n_checks++;
        if (stat_valid !== 1'b0 || dropped !== 8'h0) begin
            n_fail++;
            $display("FAIL ignore_no_sample: valid=%b dropped=%0d want 0/0", stat_valid, dropped);
        end
        realign();
        send_run(d, 2, 1'b1);
        send_run(e, 0, 1'b1);
        w = '{a, b, d, e};
        wait_valid(k);
        n_checks++;
        if (k !== 3 || {stat_min, stat_max, stat_sum, stat_avg} !== exp_stats(w)) begin
            n_fail++;
            $display("FAIL ignore_window: got %h after %0d cycles want %h after 3",
                     {stat_min, stat_max, stat_sum, stat_avg}, k, exp_stats(w));
        end
        realign();
    endtask

    task automatic test_hold_drop();
        int w[4];
        int k;
        logic [33:0] held;
        stat_ready = 1'b0;
        random_widths(w);
        send_window(w);
        wait_valid(k);
        held = exp_stats(w);
        n_checks++;
        if (k !== 3 || {stat_min, stat_max, stat_sum, stat_avg} !== held) begin
            n_fail++;
            $display("FAIL hold_window: got %h after %0d cycles want %h after 3",
                     {stat_min, stat_max, stat_sum, stat_avg}, k, held);
        end
        realign();
        for (int i = 0; i < 2; i++) begin
            send_run(int'($urandom_range(1, 30)), 2, 1'b1);
            exp_drop++;
        end
        @(negedge clk);
        n_checks++;
        if (stat_valid !== 1'b1 || {stat_min, stat_max, stat_sum, stat_avg} !== held) begin
            n_fail++;
            $display("FAIL hold_stable: valid=%b stats=%h want 1/%h",
                     stat_valid, {stat_min, stat_max, stat_sum, stat_avg}, held);
        end
        n_checks++;
        if (dropped !== 8'(exp_drop)) begin
            n_fail++;
            $display("FAIL hold_dropped: got %0d want %0d", dropped, exp_drop);
        end
        realign();
        stat_ready = 1'b1;
        realign();
        stat_ready = 1'b0;
        @(negedge clk);
        n_checks++;
        if (stat_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_release: valid=%b want 0", stat_valid);
        end
        realign();
        w = '{4, 4, 4, 4};
        send_window(w);
        wait_valid(k);
        n_checks++;
        if (k !== 3 || {stat_min, stat_max, stat_sum, stat_avg} !== exp_stats(w)) begin
            n_fail++;
            $display("FAIL hold_next_window: got %h after %0d cycles want %h after 3",
                     {stat_min, stat_max, stat_sum, stat_avg}, k, exp_stats(w));
        end
        realign();
        stat_ready = 1'b1;
        realign();
    endtask

    task automatic test_reset_in_hold();
        int w[4];
        int k;
        stat_ready = 1'b0;
        random_widths(w);
        send_window(w);
        wait_valid(k);
        realign();
        send_run(int'($urandom_range(1, 30)), 2, 1'b1);
        rst = 1'b1;
        Q   = 4'hF;
        realign();
        rst = 1'b0;
        exp_drop = 0;
        @(negedge clk);
        n_checks++;
        if (stat_valid !== 1'b0 || {stat_min, stat_max, stat_sum, stat_avg} !== 34'h0) begin
            n_fail++;
            $display("FAIL rst_hold_outputs: valid=%b stats=%h want 0/0",
                     stat_valid, {stat_min, stat_max, stat_sum, stat_avg});
        end
        n_checks++;
        if (dropped !== 8'h0 || dropped2 !== 2'h0) begin
            n_fail++;
            $display("FAIL rst_hold_dropped: got %0d/%0d want 0/0", dropped, dropped2);
        end
        // The run straddling reset release lasts 4 sampled cycles in total.
        repeat (3) @(posedge clk);
        #1;
        Q = idle_q();
        realign();
        realign();
        stat_ready = 1'b1;
        w[0] = 4;
        for (int i = 1; i < N; i++) w[i] = int'($urandom_range(1, 40));
        send_run(w[1], 2, 1'b1);
        send_run(w[2], 2, 1'b1);
        send_run(w[3], 0, 1'b1);
        wait_valid(k);
        n_checks++;
        if (k !== 3 || {stat_min, stat_max, stat_sum, stat_avg} !== exp_stats(w)) begin
            n_fail++;
            $display("FAIL rst_fresh_window: got %h after %0d cycles want %h after 3",
                     {stat_min, stat_max, stat_sum, stat_avg}, k, exp_stats(w));
        end
        realign();
    endtask

    task automatic test_saturation();
        int w[4];
        int k;
        rst = 1'b1;
        Q   = 4'h0;
        realign();
        rst = 1'b0;
        exp_drop = 0;
        realign();
        stat_ready = 1'b0;
        random_widths(w);
        send_window(w);
        wait_valid(k);
        n_checks++;
        if (v2 !== 1'b1 || {min2, max2, sum2, avg2} !== exp_stats(w)) begin
            n_fail++;
            $display("FAIL sat_window: valid=%b stats=%h want 1/%h", v2, {min2, max2, sum2, avg2}, exp_stats(w));
        end
        realign();
        for (int i = 0; i < 5; i++) begin
            send_run(int'($urandom_range(1, 20)), 2, 1'b1);
            exp_drop++;
        end
        @(negedge clk);
        n_checks++;
        if (dropped2 !== 2'(sat(exp_drop, 3))) begin
            n_fail++;
            $display("FAIL sat_dropped_w2: got %0d want %0d", dropped2, sat(exp_drop, 3));
        end
        n_checks++;
        if (dropped !== 8'(sat(exp_drop, 255))) begin
            n_fail++;
            $display("FAIL sat_dropped_w8: got %0d want %0d", dropped, sat(exp_drop, 255));
        end
        realign();
        stat_ready = 1'b1;
        realign();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_truncation();
        test_random_windows();
        test_ignored_events();
        test_hold_drop();
        test_reset_in_hold();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
